// File: rtl/serial_frame_tx_if.sv
// Handshake and line bundle for serial_frame_tx.
// master: word source side; slave: the transmitter.
interface serial_frame_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              tx_valid_i;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_ready_o;
    logic              tx_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output tx_valid_i,
        output tx_data_i,
        input  tx_ready_o,
        input  tx_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  tx_valid_i,
        input  tx_data_i,
        output tx_ready_o,
        output tx_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit (0), DATA_W data bits LSB-first,
// optional even-parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: SERIAL_TX_PARITY_EN adds the even-parity bit before STOP.
// All outputs are flops loaded from the next-state values, so the line changes on the
// same edge as the state it reflects.
module serial_frame_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input logic              clk,
    input logic              reset,
    serial_frame_tx_if.slave bus
);

    localparam int unsigned PeriodW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BitW    = $clog2(DATA_W) + 1;

    localparam logic [PeriodW-1:0] PeriodMax = PeriodW'(CLKS_PER_BIT - 1);
    localparam logic [PeriodW-1:0] PeriodOne = PeriodW'(1);
    localparam logic [BitW-1:0]    BitMax    = BitW'(DATA_W - 1);
    localparam logic [BitW-1:0]    BitOne    = BitW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef SERIAL_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [PeriodW-1:0]  period_q, period_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic wrap;
    assign wrap = (period_q == PeriodMax);

    // State, counters, shift register and output flops; reset abandons any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            period_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic: handshake in idle, then advance only on period wrap.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != StIdle) begin
            period_d = wrap ? '0 : period_q + PeriodOne;
        end
        unique case (state_q)
            StIdle: begin
                if (bus.tx_valid_i && ready_q) begin
                    shift_d  = bus.tx_data_i;
                    period_d = '0;
                    bit_d    = '0;
                    state_d  = StStart;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^bus.tx_data_i;
`endif
                end
            end
            StStart: begin
                if (wrap) state_d = StData;
            end
            StData: begin
                if (wrap) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BitOne;
                    if (bit_q == BitMax) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (wrap) state_d = StStop;
            end
`endif
            StStop: begin
                if (wrap) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output values for the state being entered, registered alongside it.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
        unique case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign bus.tx_o       = tx_q;
    assign bus.tx_ready_o = ready_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one DUT at DATA_W=8/CLKS_PER_BIT=4 and one at
// DATA_W=1/CLKS_PER_BIT=1. Build with SERIAL_TX_PARITY_EN to include the parity test.
module tb_serial_frame_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 2 + DW + P;
    localparam int F     = NBITS * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_frame_tx_if #(.DATA_W(8)) bus ();
    serial_frame_tx_if #(.DATA_W(1)) sbus ();

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut_min (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for bit slot b of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (P == 1 && b == DW + 1) return ^d;
        return 1'b1;
    endfunction

    // Called #1 after the handshake edge; returns in the done cycle.
    task automatic check_frame(input logic [7:0] d, input string name);
        for (int c = 0; c < F; c++) begin
            checks++;
            if (bus.tx_o !== exp_bit(d, c / CPB)) begin
                errors++;
                $display("FAIL %s tx cycle %0d: got %b want %b", name, c, bus.tx_o,
                         exp_bit(d, c / CPB));
            end
            checks++;
            if ({bus.tx_ready_o, bus.busy_o, bus.done_o} !== 3'b010) begin
                errors++;
                $display("FAIL %s ready/busy/done cycle %0d: got %b want 010", name, c,
                         {bus.tx_ready_o, bus.busy_o, bus.done_o});
            end
            step();
        end
        checks++;
        if ({bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o} !== 4'b1101) begin
            errors++;
            $display("FAIL %s done cycle tx/ready/busy/done: got %b want 1101", name,
                     {bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o});
        end
    endtask

    task automatic test_reset();
        bus.tx_valid_i  = 1'b0;
        bus.tx_data_i   = '0;
        sbus.tx_valid_i = 1'b0;
        sbus.tx_data_i  = '0;
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step();
            else begin
                reset = 1'b1;
                step();
            end
            checks++;
            if ({bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o} !== 4'b1100) begin
                errors++;
                $display("FAIL reset main cycle %0d: got %b want 1100", i,
                         {bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o});
            end
            checks++;
            if ({sbus.tx_o, sbus.tx_ready_o, sbus.busy_o, sbus.done_o} !== 4'b1100) begin
                errors++;
                $display("FAIL reset min cycle %0d: got %b want 1100", i,
                         {sbus.tx_o, sbus.tx_ready_o, sbus.busy_o, sbus.done_o});
            end
        end
    endtask

    task automatic test_single_frame();
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'hA5;
        step();
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = 8'h5A;  // must not disturb the frame in flight
        check_frame(8'hA5, "single_a5");
        step();
        checks++;
        if ({bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o} !== 4'b1100) begin
            errors++;
            $display("FAIL single_after: got %b want 1100",
                     {bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o});
        end
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'hA5;
        step();
        bus.tx_valid_i = 1'b0;
        check_frame(8'hA5, "parity_a5");
        step();
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'h01;
        step();
        bus.tx_valid_i = 1'b0;
        for (int c = 0; c < 9 * CPB; c++) step();
        checks++;
        if (bus.tx_o !== 1'b1) begin
            errors++;
            $display("FAIL parity_01 bit: got %b want 1", bus.tx_o);
        end
        for (int c = 9 * CPB; c < F; c++) step();
        checks++;
        if (bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL parity_01 done at 44: got %b want 1", bus.done_o);
        end
        step();
    endtask
`endif

    task automatic test_back_to_back();
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'h00;
        step();
        bus.tx_data_i = 8'hFF;  // valid stays high across the frame
        check_frame(8'h00, "b2b_first");
        step();
        bus.tx_valid_i = 1'b0;
        check_frame(8'hFF, "b2b_second");
        step();
        checks++;
        if ({bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o} !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_after: got %b want 1100",
                     {bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o});
        end
    endtask

    task automatic test_mid_frame_reset();
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'h3C;
        step();
        bus.tx_valid_i = 1'b0;
        for (int c = 0; c < 10; c++) step();
        checks++;
        if (bus.tx_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre tx: got %b want 0", bus.tx_o);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o} !== 4'b1100) begin
            errors++;
            $display("FAIL midreset_async: got %b want 1100",
                     {bus.tx_o, bus.tx_ready_o, bus.busy_o, bus.done_o});
        end
        step();
        step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (bus.done_o !== 1'b0 || bus.tx_o !== 1'b1) begin
                errors++;
                $display("FAIL midreset_idle cycle %0d: got done=%b tx=%b want done=0 tx=1",
                         c, bus.done_o, bus.tx_o);
            end
        end
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'h3C;
        step();
        bus.tx_valid_i = 1'b0;
        check_frame(8'h3C, "midreset_3c");
        step();
    endtask

    task automatic test_min_config();
        sbus.tx_valid_i = 1'b1;
        sbus.tx_data_i  = 1'b1;
        step();
        sbus.tx_valid_i = 1'b0;
        sbus.tx_data_i  = 1'b0;
        for (int c = 0; c < 3 + P; c++) begin
            checks++;
            if ({sbus.tx_o, sbus.busy_o, sbus.done_o} !== {(c != 0), 2'b10}) begin
                errors++;
                $display("FAIL min tx/busy/done cycle %0d: got %b want %b", c,
                         {sbus.tx_o, sbus.busy_o, sbus.done_o}, {(c != 0), 2'b10});
            end
            step();
        end
        checks++;
        if ({sbus.tx_o, sbus.tx_ready_o, sbus.busy_o, sbus.done_o} !== 4'b1101) begin
            errors++;
            $display("FAIL min done: got %b want 1101",
                     {sbus.tx_o, sbus.tx_ready_o, sbus.busy_o, sbus.done_o});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_frame();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_mid_frame_reset();
        test_min_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
